// File: rtl/axi_rd_mem_responder.sv
// AXI4 read-channel responder fronting a 1-cycle-latency synchronous SRAM.
// Serves FIXED/INCR/WRAP bursts, buffering beats in a 2-entry skid FIFO.
//
// Ports:
//   clock, reset       : clock, async active-low reset
//   ar*                : AR request (arvalid/arready, araddr, arid, arlen,
//                        arsize, arburst)
//   r*                 : R beat (rvalid/rready, rdata, rresp, rlast, rid)
//   mem_en, mem_addr   : SRAM read request (word address)
//   mem_rdata          : SRAM data, valid the cycle after mem_en
//
// Optional feature macro: AXI_RD_RSP_RANGE_CHK_EN
//   defined   -> beats whose word address is >= MEM_DEPTH return DECERR
//   undefined -> word address wraps modulo MEM_DEPTH (power of two)

module axi_rd_mem_responder #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 64,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 1024,
    localparam int MA_W     = $clog2(MEM_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arvalid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [ID_W-1:0]   arid,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    output logic              arready,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic [ID_W-1:0]   rid,
    output logic              mem_en,
    output logic [MA_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] BEAT_SIZE = 3'($clog2(DATA_W / 8));
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;
    localparam logic [1:0] RESP_DEC  = 2'b11;

    typedef enum logic [0:0] {
        IDLE,
        BURST
    } state_t;

    state_t state_q, state_d;

    logic              arready_q;
    logic [ADDR_W-1:0] ba_q;
    logic [7:0]        len_q;
    logic [1:0]        burst_q;
    logic [ID_W-1:0]   id_q;
    logic              err_q;
    logic [8:0]        issue_cnt_q;

    // One-deep tag pipe tracking the beat whose SRAM data returns next.
    logic              pipe_vld_q;
    logic [1:0]        pipe_resp_q;
    logic              pipe_last_q;

    logic [DATA_W-1:0] fifo_data_q [2];
    logic [1:0]        fifo_resp_q [2];
    logic              fifo_last_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;

    logic              accept;
    logic              pop;
    logic              issue;
    logic              beat_last;
    logic [1:0]        beat_resp;
    logic              oor;
    logic              bad_req;
    logic [ADDR_W-1:0] ba_next;
    logic [ADDR_W-1:0] wrap_mask;

    assign arready  = arready_q;
    assign rvalid   = (cnt_q != 2'd0);
    assign rdata    = fifo_data_q[rd_ptr_q];
    assign rresp    = fifo_resp_q[rd_ptr_q];
    assign rlast    = fifo_last_q[rd_ptr_q];
    assign rid      = id_q;
    assign mem_addr = ba_q[MA_W+3:4];

`ifdef AXI_RD_RSP_RANGE_CHK_EN
    assign oor = (ba_q >> 4) >= ADDR_W'(MEM_DEPTH);
`else
    assign oor = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        pop       = 1'b0;
        issue     = 1'b0;
        mem_en    = 1'b0;
        beat_last = 1'b0;
        beat_resp = RESP_OKAY;
        bad_req   = 1'b0;
        ba_next   = ba_q;
        wrap_mask = {{(ADDR_W-12){1'b0}}, len_q, 4'hF};

        bad_req = (arsize != BEAT_SIZE) || (arburst == 2'b11) ||
                  ((arburst == 2'b10) &&
                   !((arlen == 8'd1) || (arlen == 8'd3) ||
                     (arlen == 8'd7) || (arlen == 8'd15)));

        if (err_q) begin
            beat_resp = RESP_SLV;
        end else if (oor) begin
            beat_resp = RESP_DEC;
        end

        case (burst_q)
            2'b00:   ba_next = ba_q;
            2'b10:   ba_next = (ba_q & ~wrap_mask) |
                               ((ba_q + ADDR_W'(16)) & wrap_mask);
            default: ba_next = ba_q + ADDR_W'(16);
        endcase

        pop       = rvalid && rready;
        beat_last = (issue_cnt_q == {1'b0, len_q});

        case (state_q)
            IDLE: begin
                accept = arvalid && arready_q;
                if (accept) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                // Credit the beat leaving this cycle so a steady stream
                // keeps one read in flight and one entry buffered.
                issue = (issue_cnt_q <= {1'b0, len_q}) &&
                        (({1'b0, cnt_q} + {2'b0, pipe_vld_q} -
                          {2'b0, pop}) < 3'd2);
                mem_en = issue && (beat_resp == RESP_OKAY);
                if (pop && rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            arready_q   <= 1'b0;
            ba_q        <= '0;
            len_q       <= '0;
            burst_q     <= '0;
            id_q        <= '0;
            err_q       <= 1'b0;
            issue_cnt_q <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_resp_q <= '0;
            pipe_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            arready_q  <= (state_d == IDLE);
            pipe_vld_q <= issue;
            if (issue) begin
                pipe_resp_q <= beat_resp;
                pipe_last_q <= beat_last;
                ba_q        <= ba_next;
                issue_cnt_q <= issue_cnt_q + 9'd1;
            end
            if (accept) begin
                ba_q        <= araddr;
                len_q       <= arlen;
                burst_q     <= arburst;
                id_q        <= arid;
                err_q       <= bad_req;
                issue_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_resp_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (pipe_vld_q) begin
                fifo_data_q[wr_ptr_q] <= (pipe_resp_q == RESP_OKAY) ?
                                         mem_rdata : '0;
                fifo_resp_q[wr_ptr_q] <= pipe_resp_q;
                fifo_last_q[wr_ptr_q] <= pipe_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, pipe_vld_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_axi_rd_mem_responder.sv
// Directed bench for axi_rd_mem_responder: vector table of bursts plus
// hand sequences for a 256-beat burst and reset mid-burst.

module tb_axi_rd_mem_responder;

    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] SE = 2'b10;
`ifdef AXI_RD_RSP_RANGE_CHK_EN
    localparam logic [1:0] HI = 2'b11;
`else
    localparam logic [1:0] HI = 2'b00;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         arvalid;
    logic [63:0]  araddr;
    logic [3:0]   arid;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arready;
    logic         rvalid;
    logic         rready;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic [3:0]   rid;
    logic         mem_en;
    logic [9:0]   mem_addr;
    logic [127:0] mem_rdata = '0;

    logic [127:0] mem [1024];
    int           en_cnt = 0;
    int           total = 0;
    int           bad = 0;

    always #5 clock = ~clock;

    axi_rd_mem_responder dut (
        .clock     (clock),
        .reset     (reset),
        .arvalid   (arvalid),
        .araddr    (araddr),
        .arid      (arid),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arready   (arready),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rid       (rid),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clock) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            en_cnt    <= en_cnt + 1;
        end
    end

    function automatic logic [127:0] init_word(input int i);
        return {32'hDEAD0000 ^ i, i * 7, 32'hC0DE0000 + i, i};
    endfunction

    typedef struct packed {
        logic [63:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0]       id;
        logic [3:0]       rdy;
        logic [3:0]       nb;
        logic [3:0][9:0]  w;
        logic [3:0][1:0]  rs;
    } vec_t;

    function automatic vec_t mk(
        input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
        input logic [1:0] b, input logic [3:0] id, input logic [3:0] rdy,
        input logic [3:0] nb,
        input logic [9:0] w0, input logic [9:0] w1,
        input logic [9:0] w2, input logic [9:0] w3,
        input logic [1:0] r0, input logic [1:0] r1,
        input logic [1:0] r2, input logic [1:0] r3);
        vec_t v;
        v.addr = a; v.len = l; v.size = s; v.burst = b;
        v.id = id; v.rdy = rdy; v.nb = nb;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.rs[0] = r0; v.rs[1] = r1; v.rs[2] = r2; v.rs[3] = r3;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic do_ar(input logic [63:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b,
                         input logic [3:0] id);
        int n;
        @(negedge clock);
        arvalid = 1'b1; araddr = a; arlen = l;
        arsize = s; arburst = b; arid = id;
        n = 0;
        while (!arready && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("ar_wait", {255'd0, arready}, 256'd1);
        @(posedge clock);
        #1 arvalid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int beats, cyc, first, okc, base;
        logic stalled;
        logic [135:0] held;
        logic [127:0] ed;
        base = en_cnt;
        okc = 0;
        for (int i = 0; i < int'(v.nb); i++) begin
            if (v.rs[i] == OK) okc++;
        end
        rready = 1'b0;
        do_ar(v.addr, v.len, v.size, v.burst, v.id);
        beats = 0; cyc = 0; first = -1; stalled = 1'b0; held = '0;
        while (beats < int'(v.nb) && cyc < 60) begin
            @(negedge clock);
            rready = v.rdy[cyc % 4];
            if (cyc == 0) chk($sformatf("v%0d_arready_busy", k),
                              {255'd0, arready}, 256'd0);
            if (rvalid && first < 0) begin
                first = cyc;
                chk($sformatf("v%0d_latency", k), 256'(cyc), 256'd2);
            end
            if (stalled) chk($sformatf("v%0d_stable", k),
                             {rvalid, rdata, rresp, rlast, rid},
                             {1'b1, held[134:0]});
            if (rvalid && rready) begin
                ed = (v.rs[beats] == OK) ? init_word(int'(v.w[beats])) : '0;
                chk($sformatf("v%0d_b%0d", k, beats),
                    {rdata, rresp, rlast, rid},
                    {ed, v.rs[beats], beats == int'(v.nb) - 1, v.id});
                beats++;
            end
            stalled = rvalid && !rready;
            held = {rvalid, rdata, rresp, rlast, rid};
            cyc++;
        end
        chk($sformatf("v%0d_beats", k), 256'(beats), 256'(v.nb));
        @(negedge clock);
        rready = 1'b0;
        chk($sformatf("v%0d_after", k), {254'd0, rvalid, arready},
            256'b01);
        chk($sformatf("v%0d_mem_en", k), 256'(en_cnt - base), 256'(okc));
    endtask

    vec_t vt [10];

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int beats, cyc, first, last_at;
        for (int i = 0; i < 1024; i++) mem[i] = init_word(i);

        vt[0] = mk(64'h40, 8'd0, 3'd4, 2'b01, 4'd3, 4'b1111, 4'd1,
                   10'd4, 10'd0, 10'd0, 10'd0, OK, OK, OK, OK);
        vt[1] = mk(64'h100, 8'd3, 3'd4, 2'b01, 4'd5, 4'b1001, 4'd4,
                   10'd16, 10'd17, 10'd18, 10'd19, OK, OK, OK, OK);
        vt[2] = mk(64'h30, 8'd3, 3'd4, 2'b10, 4'd1, 4'b1111, 4'd4,
                   10'd3, 10'd0, 10'd1, 10'd2, OK, OK, OK, OK);
        vt[3] = mk(64'h30, 8'd2, 3'd4, 2'b10, 4'd2, 4'b1111, 4'd3,
                   10'd0, 10'd0, 10'd0, 10'd0, SE, SE, SE, SE);
        vt[4] = mk(64'h80, 8'd1, 3'd3, 2'b01, 4'd4, 4'b1111, 4'd2,
                   10'd0, 10'd0, 10'd0, 10'd0, SE, SE, SE, SE);
        vt[5] = mk(64'h3FF0, 8'd1, 3'd4, 2'b01, 4'd6, 4'b1111, 4'd2,
                   10'd1023, 10'd0, 10'd0, 10'd0, OK, HI, OK, OK);
        vt[6] = mk(64'h50, 8'd2, 3'd4, 2'b00, 4'd7, 4'b0110, 4'd3,
                   10'd5, 10'd5, 10'd5, 10'd0, OK, OK, OK, OK);
        vt[7] = mk(64'h0, 8'd0, 3'd4, 2'b11, 4'd8, 4'b1111, 4'd1,
                   10'd0, 10'd0, 10'd0, 10'd0, SE, SE, SE, SE);
        vt[8] = mk(64'hFFFF_FFFF_FFFF_FFF0, 8'd1, 3'd4, 2'b01, 4'd9,
                   4'b1111, 4'd2, 10'd1023, 10'd0, 10'd0, 10'd0,
                   HI, OK, OK, OK);
        vt[9] = mk(64'h10, 8'd1, 3'd4, 2'b10, 4'd10, 4'b1010, 4'd2,
                   10'd1, 10'd0, 10'd0, 10'd0, OK, OK, OK, OK);

        reset = 1'b0; arvalid = 1'b0; araddr = '0; arid = '0;
        arlen = '0; arsize = '0; arburst = '0; rready = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_vals", {arready, rvalid, rlast, rresp, rid, rdata, mem_en},
            256'd0);
        reset = 1'b1;
        #1 chk("arready_pre", {255'd0, arready}, 256'd0);
        @(negedge clock);
        chk("arready_rise", {255'd0, arready}, 256'd1);

        for (int k = 0; k < 10; k++) run_vec(vt[k], k);

        // 256-beat burst at full rate, rlast only on the final beat
        rready = 1'b1;
        do_ar(64'h0, 8'd255, 3'd4, 2'b01, 4'd11);
        beats = 0; cyc = 0; first = -1; last_at = -1;
        while (beats < 256 && cyc < 400) begin
            @(negedge clock);
            if (rvalid && first < 0) first = cyc;
            if (rvalid && rlast) last_at = beats;
            if (rvalid) begin
                if ({rdata, rresp, rid} !== {init_word(beats), OK, 4'd11})
                    chk($sformatf("long_b%0d", beats),
                        {rdata, rresp, rid}, {init_word(beats), OK, 4'd11});
                beats++;
            end
            cyc++;
        end
        chk("long_beats", 256'(beats), 256'd256);
        chk("long_last", 256'(last_at), 256'd255);
        chk("long_rate", 256'(cyc - first), 256'd256);
        @(negedge clock);
        chk("long_after", {254'd0, rvalid, arready}, 256'b01);

        // reset asserted mid-burst
        rready = 1'b1;
        do_ar(64'h200, 8'd7, 3'd4, 2'b01, 4'd12);
        beats = 0; cyc = 0;
        while (beats < 2 && cyc < 20) begin
            @(negedge clock);
            if (rvalid) begin
                chk($sformatf("rst_b%0d", beats), {rdata, rlast},
                    {init_word(32 + beats), 1'b0});
                beats++;
            end
            cyc++;
        end
        @(negedge clock);
        reset = 1'b0;
        #1 chk("rst_async",
               {arready, rvalid, rlast, rresp, rid, rdata, mem_en}, 256'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1 chk("rst_arready_low", {255'd0, arready}, 256'd0);
        @(negedge clock);
        chk("rst_arready_up", {255'd0, arready}, 256'd1);
        run_vec(vt[0], 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
